// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared defaults and slot state encoding for the 1:2 demux
//
// Purpose : parameter defaults and the one-entry slot state type used by
//           demux_slot and demux1_2_reg.
// Ports   : none (package).

package demux_pkg;

  localparam int DEMUX_WIDTH = 8;
  localparam int DEMUX_CNT_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : demux_pkg

// File: rtl/demux1_2_reg_if.sv
// rtl/demux1_2_reg_if.sv - valid/ready word stream interface for the demux ports
//
// Purpose : one word stream (tvalid/tready/tdata) used for the input and for
//           each output channel of demux1_2_reg.
// Signals : tvalid - producer offers a word
//           tready - consumer takes the word when tvalid=1
//           tdata  - the word, WIDTH bits
// Modports: master (producer), slave (consumer).

interface demux1_2_reg_if
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) ();

  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface : demux1_2_reg_if

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register with saturating transfer counter
//
// Purpose : holds one word for a demux output channel and counts completed
//           output transfers.
// Ports   : clk_i        - clock, rising edge
//           rst_ni       - asynchronous active-low reset
//           wr_en_i      - input transfer routed to this slot this cycle
//           wr_data_i    - word to capture on wr_en_i
//           out_m        - output stream (master)
//           clr_cnt_i    - synchronous counter clear, wins over increment
//           can_accept_o - slot can take a word this cycle (empty, or
//                          full and draining now)
//           cnt_o        - completed output transfers, saturating

module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  demux1_2_reg_if.master    out_m,
  input  logic              clr_cnt_i,
  output logic              can_accept_o,
  output logic [CNT_W-1:0]  cnt_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid;
  logic             can_accept;
  logic             out_xfer;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign out_xfer = valid & out_m.tready;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a write while draining keeps the slot full with the new word
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (wr_en_i) state_d = SLOT_FULL;
      SLOT_FULL:  if (out_xfer && !wr_en_i) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    valid      = 1'b0;
    can_accept = 1'b1;
    if (state_q == SLOT_FULL) begin
      valid      = 1'b1;
      can_accept = out_m.tready;
    end
  end

  // Data is only written on a transfer, so an empty slot keeps its last word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (wr_en_i) begin
      data_q <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= '0;
    end else if (out_xfer && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign out_m.tvalid = valid;
  assign out_m.tdata  = data_q;
  assign can_accept_o = can_accept;
  assign cnt_o        = cnt_q;

endmodule : demux_slot

// File: rtl/demux1_2_reg.sv
// rtl/demux1_2_reg.sv - registered 1:2 demultiplexer with per-channel counters
//
// Purpose : steers each accepted input word to channel A_1 (sel_i=1) or
//           B_0 (sel_i=0); each channel is a one-entry demux_slot.
// Ports   : clk_i     - clock, rising edge
//           rst_ni    - asynchronous active-low reset (release synchronous
//                       to clk_i, supplied by the surrounding design)
//           in_s      - input stream (slave)
//           sel_i     - route select, sampled with in_s.tdata
//           a_1_m     - channel A_1 output stream (master)
//           b_0_m     - channel B_0 output stream (master)
//           clr_cnt_i - synchronous clear of both counters
//           cnt_a_1_o - completed A_1 transfers, saturating
//           cnt_b_0_o - completed B_0 transfers, saturating

module demux1_2_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  demux1_2_reg_if.slave    in_s,
  input  logic             sel_i,
  demux1_2_reg_if.master   a_1_m,
  demux1_2_reg_if.master   b_0_m,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] cnt_a_1_o,
  output logic [CNT_W-1:0] cnt_b_0_o
);

  logic a_1_can_accept;
  logic b_0_can_accept;
  logic in_xfer;

  // Ready follows only the selected slot, so a stalled channel never blocks
  // words aimed at the other one; it does not look at tvalid.
  assign in_s.tready = sel_i ? a_1_can_accept : b_0_can_accept;
  assign in_xfer     = in_s.tvalid & in_s.tready;

  demux_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot_a_1 (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_en_i      (in_xfer & sel_i),
    .wr_data_i    (in_s.tdata),
    .out_m        (a_1_m),
    .clr_cnt_i    (clr_cnt_i),
    .can_accept_o (a_1_can_accept),
    .cnt_o        (cnt_a_1_o)
  );

  demux_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot_b_0 (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_en_i      (in_xfer & ~sel_i),
    .wr_data_i    (in_s.tdata),
    .out_m        (b_0_m),
    .clr_cnt_i    (clr_cnt_i),
    .can_accept_o (b_0_can_accept),
    .cnt_o        (cnt_b_0_o)
  );

endmodule : demux1_2_reg

// File: tb/tb_demux1_2_reg.sv
// tb/tb_demux1_2_reg.sv - self-checking bench for demux1_2_reg

module tb_demux1_2_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       sel;
  logic       a_ready;
  logic       b_ready;
  logic       clr;

  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_a_s, cnt_b_s;

  int total = 0;
  int bad   = 0;

  // Reference model: per-channel word queues (depth 1), last word written,
  // transfer counts for a 16-bit and a 4-bit counter
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] last_a, last_b;
  int ca16, cb16, ca4, cb4;

  always #5 clk = ~clk;

  demux1_2_reg_if #(.WIDTH(8)) in_if ();
  demux1_2_reg_if #(.WIDTH(8)) a_if ();
  demux1_2_reg_if #(.WIDTH(8)) b_if ();
  demux1_2_reg_if #(.WIDTH(8)) in2_if ();
  demux1_2_reg_if #(.WIDTH(8)) a2_if ();
  demux1_2_reg_if #(.WIDTH(8)) b2_if ();

  assign in_if.tvalid  = in_valid;
  assign in_if.tdata   = in_data;
  assign a_if.tready   = a_ready;
  assign b_if.tready   = b_ready;
  assign in2_if.tvalid = in_valid;
  assign in2_if.tdata  = in_data;
  assign a2_if.tready  = a_ready;
  assign b2_if.tready  = b_ready;

  demux1_2_reg #(.WIDTH(8), .CNT_W(16)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_s      (in_if),
    .sel_i     (sel),
    .a_1_m     (a_if),
    .b_0_m     (b_if),
    .clr_cnt_i (clr),
    .cnt_a_1_o (cnt_a),
    .cnt_b_0_o (cnt_b)
  );

  demux1_2_reg #(.WIDTH(8), .CNT_W(4)) dut_s (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_s      (in2_if),
    .sel_i     (sel),
    .a_1_m     (a2_if),
    .b_0_m     (b2_if),
    .clr_cnt_i (clr),
    .cnt_a_1_o (cnt_a_s),
    .cnt_b_0_o (cnt_b_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_add(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    last_a = 8'h00;
    last_b = 8'h00;
    ca16 = 0; cb16 = 0; ca4 = 0; cb4 = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_a_valid"}, a_if.tvalid, qa.size() != 0);
    chk({tag, "_a_data"},  a_if.tdata,  last_a);
    chk({tag, "_b_valid"}, b_if.tvalid, qb.size() != 0);
    chk({tag, "_b_data"},  b_if.tdata,  last_b);
    chk({tag, "_cnt_a"},   cnt_a,   ca16);
    chk({tag, "_cnt_b"},   cnt_b,   cb16);
    chk({tag, "_cnt_a4"},  cnt_a_s, ca4);
    chk({tag, "_cnt_b4"},  cnt_b_s, cb4);
  endtask

  // One clock: check ready against the model, advance the model at the edge
  // with the inputs held, then check the registered outputs.
  task automatic cycle(input string tag);
    logic exp_rdy;
    logic acc;
    #1;
    exp_rdy = sel ? (qa.size() == 0 || a_ready) : (qb.size() == 0 || b_ready);
    chk({tag, "_in_ready"}, in_if.tready, exp_rdy);
    chk({tag, "_in_ready4"}, in2_if.tready, exp_rdy);
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (qa.size() != 0 && a_ready) begin
      void'(qa.pop_front());
      ca16 = sat_add(ca16, 65535);
      ca4  = sat_add(ca4, 15);
    end
    if (qb.size() != 0 && b_ready) begin
      void'(qb.pop_front());
      cb16 = sat_add(cb16, 65535);
      cb4  = sat_add(cb4, 15);
    end
    if (clr) begin
      ca16 = 0; cb16 = 0; ca4 = 0; cb4 = 0;
    end
    if (acc) begin
      if (sel) begin qa.push_back(in_data); last_a = in_data; end
      else     begin qb.push_back(in_data); last_b = in_data; end
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; sel = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0; clr = 1'b0;
    model_reset();
    #3;
    chk_all("reset");
    chk("reset_in_ready", in_if.tready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // First word straight after release
    in_valid = 1'b1; sel = 1'b1; in_data = 8'h5A; a_ready = 1'b1; b_ready = 1'b1;
    cycle("first");
    chk("first_a_data_lit", a_if.tdata, 8'h5A);
    chk("first_b_valid_lit", b_if.tvalid, 1'b0);
    in_valid = 1'b0;
    cycle("first_drain");
    chk("first_cnt_lit", cnt_a, 16'd1);

    // Back-pressure on A_1
    a_ready = 1'b0; in_valid = 1'b1; sel = 1'b1; in_data = 8'h11;
    cycle("bp_w1");
    in_data = 8'h22;
    cycle("bp_w2_stall");
    chk("bp_held_lit", a_if.tdata, 8'h11);
    cycle("bp_w2_stall2");

    // Independence: B_0 accepts while A_1 stalled
    sel = 1'b0; in_data = 8'h33; b_ready = 1'b0;
    cycle("indep");
    chk("indep_b_lit", b_if.tdata, 8'h33);
    chk("indep_a_lit", a_if.tdata, 8'h11);

    // Release A_1: 0x22 replaces 0x11 in the same cycle
    sel = 1'b1; in_data = 8'h22; a_ready = 1'b1; b_ready = 1'b1;
    cycle("bp_release");
    chk("bp_second_lit", a_if.tdata, 8'h22);
    in_valid = 1'b0;
    cycle("bp_drain");

    // Clear, then stream 100 words alternating select
    clr = 1'b1;
    cycle("clr");
    clr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; sel = (i % 2 == 0); in_data = 8'($urandom);
      cycle("stream");
      chk("stream_ready_lit", in_if.tready, 1'b1);
    end
    in_valid = 1'b0;
    cycle("stream_drain");
    chk("stream_cnt_a_lit", cnt_a, 16'd50);
    chk("stream_cnt_b_lit", cnt_b, 16'd50);
    chk("sat_cnt_a4_lit", cnt_a_s, 4'd15);

    // Clear wins over a simultaneous transfer
    a_ready = 1'b0; in_valid = 1'b1; sel = 1'b1; in_data = 8'h77;
    cycle("clrw_load");
    in_valid = 1'b0; a_ready = 1'b1; clr = 1'b1;
    cycle("clrw");
    chk("clrw_cnt_a4_lit", cnt_a_s, 4'd0);
    chk("clrw_cnt_a_lit", cnt_a, 16'd0);
    clr = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      sel      = 1'($urandom);
      in_data  = 8'($urandom);
      a_ready  = ($urandom_range(0, 3) != 0);
      b_ready  = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 31) == 0);
      cycle("rand");
    end
    clr = 1'b0;

    // Reset mid-operation with both channels full
    a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1;
    sel = 1'b1; in_data = 8'hA1;
    cycle("mid_fill_a");
    sel = 1'b0; in_data = 8'hB0;
    cycle("mid_fill_b");
    chk("mid_full_a_lit", a_if.tvalid, 1'b1);
    chk("mid_full_b_lit", b_if.tvalid, 1'b1);
    in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("mid_rst");
    chk("mid_rst_a_valid_lit", a_if.tvalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst");
    cycle("post_rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_demux1_2_reg

// File: doc/demux1_2_reg.md
DEMUX1_2_REG -- requirements
Module: demux1_2_reg

Interface
REQ-001 Parameter WIDTH, default 8: data width of input and both output channels.
REQ-002 Parameter CNT_W, default 16: width of each per-output transfer counter.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 IN_VALID  input  1  input word offered.
REQ-006 IN_READY  output  1  input word accepted this cycle when IN_VALID=1.
REQ-007 IN_DATA  input  WIDTH  input word.
REQ-008 S  input  1  route select, sampled with IN_DATA: 1 routes to channel A_1, 0 routes to channel B_0.
REQ-009 A_1_VALID / B_0_VALID  output  1  channel holds a word.
REQ-010 A_1_READY / B_0_READY  input  1  downstream takes the word this cycle when VALID=1.
REQ-011 A_1_DATA / B_0_DATA  output  WIDTH  channel word; stable while VALID=1 and READY=0.
REQ-012 CLR_CNT  input  1  synchronous clear of both counters.
REQ-013 CNT_A_1 / CNT_B_0  output  CNT_W  completed output transfers per channel, saturating.

Function
REQ-014 Each channel SHALL have a one-entry holding register with states EMPTY and FULL.
REQ-015 Input handshake SHALL be IN_VALID & IN_READY; output handshake SHALL be X_VALID & X_READY.
REQ-016 IN_READY SHALL be 1 if the channel selected by S is EMPTY, or FULL with its READY=1 this cycle; IN_READY SHALL NOT depend on IN_VALID.
REQ-017 An accepted word SHALL appear on the selected channel's DATA with VALID=1 exactly one cycle after acceptance; latency is 1 cycle.
REQ-018 The non-selected channel's register and VALID SHALL be unaffected by an input transfer.
REQ-019 EMPTY->FULL on input transfer. FULL->EMPTY on output transfer with no input transfer. FULL->FULL with new data on simultaneous output and input transfer, giving 1 word/cycle sustained per channel.
REQ-020 A FULL channel with READY=0 SHALL hold DATA and VALID unchanged. It SHALL stall only input words selecting it, and SHALL NOT stall words selecting the other channel.
REQ-021 Word order SHALL be preserved per channel. No ordering guarantee applies across channels.
REQ-022 DATA of an EMPTY channel is don't-care. The RTL SHALL hold the last value.
REQ-023 A counter SHALL increment by 1 on each output transfer of its channel and saturate at 2^CNT_W-1 with no wrap.
REQ-024 CLR_CNT=1 SHALL zero both counters next edge and SHALL win over a simultaneous increment.
REQ-025 IN_VALID=0 SHALL cause no state change regardless of S or IN_DATA.

Reset
REQ-026 When RST_N=0, both channels SHALL be EMPTY, both VALID=0, both DATA=0, both counters=0, and IN_READY=1 once reset releases. The reset takes effect asynchronously.
REQ-027 Reset asserted mid-transfer SHALL discard held words with no partial output.
REQ-028 Deassertion SHALL be used synchronized to CLK by the top level. The first transfer is allowed on the first edge after release.

Structure
REQ-029 Shared package demux_pkg SHALL hold WIDTH and CNT_W defaults and the slot state encoding (EMPTY=0, FULL=1).
REQ-030 One sub-module demux_slot (one-entry holding register plus saturating counter) SHALL be instantiated twice, for A_1 and B_0.
REQ-031 Top level demux1_2_reg SHALL contain only the select steering and the IN_READY logic.

Verification
REQ-032 After reset: IN_VALID=1, S=1, IN_DATA=0x5A, A_1_READY=1 -> next cycle A_1_VALID=1, A_1_DATA=0x5A, B_0_VALID=0; CNT_A_1=1 one cycle later.
REQ-033 Back-pressure: A_1_READY=0, send 0x11 then 0x22 with S=1 -> 0x11 held; IN_READY=0 on the second word. A_1_READY=1 -> 0x11 then 0x22 in order, no loss or duplicate.
REQ-034 Independence: A_1 FULL and stalled, send 0x33 with S=0 -> accepted, B_0_DATA=0x33 next cycle, A_1 unchanged.
REQ-035 Streaming: 100 consecutive words with alternating S, both READY=1 -> IN_READY constantly 1, CNT_A_1=50, CNT_B_0=50.
REQ-036 Saturation/clear: CNT_W=4 with 20 A_1 transfers -> CNT_A_1=15. CLR_CNT=1 together with a transfer -> CNT_A_1=0.
REQ-037 Reset mid-operation: both channels FULL, pulse RST_N=0 -> both VALID=0 immediately, both counters=0, no output transfer observed.
